multiport_regfile_ram: RTL

Parametrised successor to the 16-bit dual-read distributed RAM. It adds a configurable read-port count, byte-lane write enables, optional write-first bypass, an optional hardwired-zero entry 0 (RISC-V x0), and a sequenced clear engine. Memory reads stay combinational (distributed style), so the block serves as the CPU register file or as small scratch memory in the multi-cycle datapath.

---
 rtl/multiport_regfile_ram.sv | 106 ++++++++++
 1 files changed

// File: rtl/multiport_regfile_ram.sv
// Multi-port register file / scratch RAM: combinational reads, byte-lane writes, optional
// write-first bypass, optional hardwired-zero entry 0, and a sequenced clear sweep.
module multiport_regfile_ram #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int RD_PORTS  = 2,
  parameter int BYPASS    = 0,
  parameter int ZERO_REG0 = 0
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         clear,
  input  logic                         we,
  input  logic [DATA_W/8-1:0]          be,
  input  logic [ADDR_W-1:0]            write_addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   read_addr,
  output logic [RD_PORTS*DATA_W-1:0]   read_data,
  output logic                         busy
);

  localparam int                NB    = DATA_W / 8;
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_busy;
  logic                w_wr_en;

  // Entries beyond DEPTH, and entry 0 when hardwired to zero, are neither written nor read.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LIMIT) && !((ZERO_REG0 != 0) && (a == '0));
  endfunction

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    if (clear) begin
      w_state_nxt   = ST_CLEAR;
      w_clr_ptr_nxt = '0;
    end else if (r_state == ST_CLEAR) begin
      w_clr_ptr_nxt = r_clr_ptr + 1'b1;
      if (r_clr_ptr == LAST) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  assign w_busy  = (r_state == ST_CLEAR);
  assign busy    = w_busy;
  assign w_wr_en = !w_busy && !clear && we && addr_ok(write_addr);

  // Array has no reset; the sweep is what makes it defined.
  always_ff @(posedge CLK) begin
    if (!clear && w_busy) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) begin
          r_mem[write_addr][8*k +: 8] <= write_data[8*k +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_word;

    assign w_ra = read_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      w_word = '0;
      if (!w_busy && addr_ok(w_ra)) begin
        w_word = r_mem[w_ra];
        if ((BYPASS != 0) && w_wr_en && (w_ra == write_addr)) begin
          for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
              w_word[8*k +: 8] = write_data[8*k +: 8];
            end
          end
        end
      end
    end

    assign read_data[p*DATA_W +: DATA_W] = w_word;
  end

endmodule
